// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencer: stage enables/flushes, PC enable, run/wait/halt
// state machine and saturating performance counters for the 5-stage pipeline.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             ID_dread,
    input  logic [4:0]       ID_rt,
    input  logic [4:0]       IF_rs,
    input  logic [4:0]       IF_rt,
    input  logic             EX_dread,
    input  logic             EX_dwrite,
    input  logic             br_taken,
    input  logic             MEM_halt,
    output logic             IF_EN,
    output logic             ID_EN,
    output logic             EX_EN,
    output logic             MEM_EN,
    output logic             IF_FLUSH,
    output logic             ID_FLUSH,
    output logic             EX_FLUSH,
    output logic             MEM_FLUSH,
    output logic             pc_en,
    output logic             halt,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redir_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DWAIT  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  redir_cnt_q, redir_cnt_d;

    logic mem_stall_s;
    logic lduse_s;
    logic if_en_s, id_en_s, ex_en_s, mem_en_s;
    logic if_flush_s, id_flush_s, ex_flush_s, mem_flush_s;
    logic pc_en_s, halt_s, redirect_s;
    logic count_en_s;

    assign mem_stall_s = (EX_dread | EX_dwrite) & ~dhit;
    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign lduse_s     = ID_dread & (ID_rt != 5'd0) & ((ID_rt == IF_rs) | (ID_rt == IF_rt));
    assign count_en_s  = (state_q != ST_HALTED);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: halt wins over a pending data access.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN, ST_DWAIT: begin
                if (MEM_halt) begin
                    state_d = ST_HALTED;
                end else if (mem_stall_s) begin
                    state_d = ST_DWAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    // Output decode; a flush is only ever issued together with its enable.
    always_comb begin
        if_en_s     = 1'b0;
        id_en_s     = 1'b0;
        ex_en_s     = 1'b0;
        mem_en_s    = 1'b0;
        if_flush_s  = 1'b0;
        id_flush_s  = 1'b0;
        ex_flush_s  = 1'b0;
        mem_flush_s = 1'b0;
        pc_en_s     = 1'b0;
        halt_s      = 1'b0;
        redirect_s  = 1'b0;
        if (RST) begin
            halt_s = 1'b0;
        end else begin
            case (state_q)
                ST_RUN, ST_DWAIT: begin
                    if (MEM_halt || mem_stall_s) begin
                        pc_en_s = 1'b0;
                    end else if (br_taken) begin
                        {if_en_s, id_en_s, ex_en_s, mem_en_s} = 4'b1111;
                        {if_flush_s, id_flush_s, ex_flush_s}  = 3'b111;
                        pc_en_s    = 1'b1;
                        redirect_s = 1'b1;
                    end else if (lduse_s) begin
                        {id_en_s, ex_en_s, mem_en_s} = 3'b111;
                        id_flush_s = 1'b1;
                    end else if (!ihit) begin
                        {if_en_s, id_en_s, ex_en_s, mem_en_s} = 4'b1111;
                        if_flush_s = 1'b1;
                    end else begin
                        {if_en_s, id_en_s, ex_en_s, mem_en_s} = 4'b1111;
                        pc_en_s = 1'b1;
                    end
                end
                ST_HALTED: halt_s = 1'b1;
                default:   halt_s = 1'b0;
            endcase
        end
    end

    // Saturating counter updates, frozen once halted.
    always_comb begin
        cyc_cnt_d   = cyc_cnt_q;
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (count_en_s) begin
            if (cyc_cnt_q != CNT_MAX) begin
                cyc_cnt_d = cyc_cnt_q + CNT_ONE;
            end else begin
                cyc_cnt_d = cyc_cnt_q;
            end
            if (!pc_en_s && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
            if (redirect_s && (redir_cnt_q != CNT_MAX)) begin
                redir_cnt_d = redir_cnt_q + CNT_ONE;
            end else begin
                redir_cnt_d = redir_cnt_q;
            end
        end else begin
            cyc_cnt_d = cyc_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cyc_cnt_q   <= {CNT_W{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
            redir_cnt_q <= {CNT_W{1'b0}};
        end else begin
            cyc_cnt_q   <= cyc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign IF_EN     = if_en_s;
    assign ID_EN     = id_en_s;
    assign EX_EN     = ex_en_s;
    assign MEM_EN    = mem_en_s;
    assign IF_FLUSH  = if_flush_s;
    assign ID_FLUSH  = id_flush_s;
    assign EX_FLUSH  = ex_flush_s;
    assign MEM_FLUSH = mem_flush_s;
    assign pc_en     = pc_en_s;
    assign halt      = halt_s;
    assign cyc_cnt   = cyc_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign redir_cnt = redir_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: an action-table model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ihit = 1'b1, dhit = 1'b1;
    logic       id_dread = 1'b0, ex_dread = 1'b0, ex_dwrite = 1'b0;
    logic       br_taken = 1'b0, mem_halt = 1'b0;
    logic [4:0] id_rt = 5'd0, if_rs = 5'd0, if_rt = 5'd0;

    logic        if_en, id_en, ex_en, mem_en, if_fl, id_fl, ex_fl, mem_fl, pc_en, halt;
    logic [31:0] cyc_cnt, stall_cnt, redir_cnt;
    logic        s_if_en, s_id_en, s_ex_en, s_mem_en, s_if_fl, s_id_fl, s_ex_fl, s_mem_fl, s_pc_en, s_halt;
    logic [3:0]  s_cyc, s_stall, s_redir;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(32)) dut (
        .CLK(clk), .RST(rst), .ihit(ihit), .dhit(dhit), .ID_dread(id_dread), .ID_rt(id_rt),
        .IF_rs(if_rs), .IF_rt(if_rt), .EX_dread(ex_dread), .EX_dwrite(ex_dwrite),
        .br_taken(br_taken), .MEM_halt(mem_halt),
        .IF_EN(if_en), .ID_EN(id_en), .EX_EN(ex_en), .MEM_EN(mem_en),
        .IF_FLUSH(if_fl), .ID_FLUSH(id_fl), .EX_FLUSH(ex_fl), .MEM_FLUSH(mem_fl),
        .pc_en(pc_en), .halt(halt), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .redir_cnt(redir_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(4)) dut_small (
        .CLK(clk), .RST(rst), .ihit(ihit), .dhit(dhit), .ID_dread(id_dread), .ID_rt(id_rt),
        .IF_rs(if_rs), .IF_rt(if_rt), .EX_dread(ex_dread), .EX_dwrite(ex_dwrite),
        .br_taken(br_taken), .MEM_halt(mem_halt),
        .IF_EN(s_if_en), .ID_EN(s_id_en), .EX_EN(s_ex_en), .MEM_EN(s_mem_en),
        .IF_FLUSH(s_if_fl), .ID_FLUSH(s_id_fl), .EX_FLUSH(s_ex_fl), .MEM_FLUSH(s_mem_fl),
        .pc_en(s_pc_en), .halt(s_halt), .cyc_cnt(s_cyc), .stall_cnt(s_stall), .redir_cnt(s_redir)
    );

    // ---------------- model ----------------
    localparam int A_FREEZE   = 0;
    localparam int A_REDIRECT = 1;
    localparam int A_LOADUSE  = 2;
    localparam int A_FETCHMISS = 3;
    localparam int A_ADVANCE  = 4;

    bit      m_halted = 1'b0;
    longint  m_cyc = 0, m_stall = 0, m_redir = 0;

    function automatic int classify();
        bit hazard;
        hazard = id_dread && (id_rt != 5'd0) && (id_rt == if_rs || id_rt == if_rt);
        if (rst || m_halted || mem_halt || ((ex_dread || ex_dwrite) && !dhit)) return A_FREEZE;
        if (br_taken) return A_REDIRECT;
        if (hazard)   return A_LOADUSE;
        if (!ihit)    return A_FETCHMISS;
        return A_ADVANCE;
    endfunction

    // {IF_EN,ID_EN,EX_EN,MEM_EN, IF_FL,ID_FL,EX_FL,MEM_FL, pc_en}
    function automatic logic [8:0] action_vec(input int a);
        case (a)
            A_REDIRECT:  return 9'b1111_1110_1;
            A_LOADUSE:   return 9'b0111_0100_0;
            A_FETCHMISS: return 9'b1111_1000_0;
            A_ADVANCE:   return 9'b1111_0000_1;
            default:     return 9'b0000_0000_0;
        endcase
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state advances on each clock edge; reset clears everything.
    always @(posedge clk or posedge rst) begin
        int a;
        if (rst) begin
            m_halted = 1'b0;
            m_cyc = 0; m_stall = 0; m_redir = 0;
        end else if (!m_halted) begin
            a = classify();
            m_cyc++;
            if (!action_vec(a)[0]) m_stall++;
            if (a == A_REDIRECT) m_redir++;
            if (mem_halt) m_halted = 1'b1;
        end
    end

    // Compare both instances against the model mid-cycle.
    always @(negedge clk) begin
        logic [9:0] exp_v;
        exp_v = {action_vec(classify()), m_halted && !rst};
        chk("ctl", {if_en, id_en, ex_en, mem_en, if_fl, id_fl, ex_fl, mem_fl, pc_en, halt}, exp_v);
        chk("ctl_small", {s_if_en, s_id_en, s_ex_en, s_mem_en, s_if_fl, s_id_fl, s_ex_fl, s_mem_fl, s_pc_en, s_halt}, exp_v);
        chk("cyc", cyc_cnt, sat(m_cyc, 32));
        chk("stall", stall_cnt, sat(m_stall, 32));
        chk("redir", redir_cnt, sat(m_redir, 32));
        chk("cyc_small", s_cyc, sat(m_cyc, 4));
        chk("stall_small", s_stall, sat(m_stall, 4));
        chk("redir_small", s_redir, sat(m_redir, 4));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_ctl", {if_en, id_en, ex_en, mem_en, if_fl, id_fl, ex_fl, mem_fl, pc_en}, 0);
        chk("rst_cyc", cyc_cnt, 0);
        rst = 1'b0;
        #1;
        chk("first_run", {if_en, id_en, ex_en, mem_en, pc_en}, 5'b11111);
        repeat (20) tick();
        chk("cyc20", cyc_cnt, 20);
        chk("cyc_sat", s_cyc, 15);

        // load-use on $t0
        id_dread = 1'b1; id_rt = 5'd8; if_rs = 5'd8;
        #1;
        chk("lduse_ifen", if_en, 0);
        chk("lduse_idfl", id_fl, 1);
        tick();
        id_dread = 1'b0; id_rt = 5'd0; if_rs = 5'd0;
        #1;
        chk("lduse_stall", stall_cnt, 1);
        chk("after_lduse_pc", pc_en, 1);
        tick();

        // register 0 exempt
        id_dread = 1'b1;
        #1;
        chk("r0_pc", pc_en, 1);
        chk("r0_ifen", if_en, 1);
        tick();
        id_dread = 1'b0;

        // data-miss wait of three cycles
        ex_dread = 1'b1; dhit = 1'b0;
        repeat (3) begin
            #1;
            chk("dwait_pc", pc_en, 0);
            chk("dwait_en", {if_en, id_en, ex_en, mem_en}, 0);
            tick();
        end
        dhit = 1'b1;
        #1;
        chk("dwait_adv", {if_en, id_en, ex_en, mem_en, pc_en}, 5'b11111);
        tick();
        ex_dread = 1'b0;
        #1;
        chk("dwait_stall", stall_cnt, 4);

        // branch overrides load-use and fetch miss
        br_taken = 1'b1; id_dread = 1'b1; id_rt = 5'd5; if_rt = 5'd5; ihit = 1'b0;
        #1;
        chk("br_flush", {if_fl, id_fl, ex_fl, mem_fl}, 4'b1110);
        chk("br_pc", pc_en, 1);
        tick();
        br_taken = 1'b0; id_dread = 1'b0; id_rt = 5'd0; if_rt = 5'd0;
        #1;
        chk("br_redir", redir_cnt, 1);
        chk("br_nostall", stall_cnt, 4);

        // fetch miss
        #1;
        chk("imiss", {if_en, if_fl, pc_en}, 3'b110);
        tick();
        ihit = 1'b1;
        #1;
        chk("imiss_stall", stall_cnt, 5);

        // halt arriving during a data stall
        ex_dwrite = 1'b1; dhit = 1'b0;
        tick();
        mem_halt = 1'b1;
        #1;
        chk("halt_freeze", {if_en, id_en, ex_en, mem_en, pc_en}, 0);
        tick();
        mem_halt = 1'b0; ex_dwrite = 1'b0; dhit = 1'b1;
        #1;
        chk("halt_set", halt, 1);
        repeat (3) tick();
        chk("halt_sticky", halt, 1);
        chk("halt_cyc", cyc_cnt, 31);
        chk("halt_stall", stall_cnt, 7);
        chk("halt_cyc_small", s_cyc, 15);
        chk("halt_en", {if_en, pc_en}, 0);

        // reset clears halt and counters
        rst = 1'b1;
        #1;
        chk("rst_halt", halt, 0);
        chk("rst_cyc2", cyc_cnt, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rerun", {if_en, id_en, ex_en, mem_en, pc_en, halt}, 6'b111110);
        tick();

        // reset in the middle of a data wait
        ex_dread = 1'b1; dhit = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_dwait_stall", stall_cnt, 0);
        tick();
        rst = 1'b0; ex_dread = 1'b0;
        #1;
        chk("rst_dwait_run", pc_en, 1);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
